// File: rtl/align_shifter_pipe_if.sv
// Handshake bundle for align_shifter_pipe.
//   in_*  : operation channel (valid/ready, operand, shift amount, mode, tag)
//   out_* : result channel (valid/ready, shifted data, sticky, tag)
// modport slave  : the shifter's view
// modport master : the producer/consumer's view
interface align_shifter_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
);
  localparam int SHW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic [TAGW-1:0]  out_tag;

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sticky, out_tag
  );

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sticky, out_tag
  );
endinterface

// File: rtl/align_shifter_pipe.sv
// Pipelined barrel shifter with sticky-bit collection.
// One stage per shift-amount bit (MSB first), each stage registered, so the
// latency is SHW cycles. The whole pipe stalls when the result is held.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : align_shifter_pipe_if.slave (in_* operation, out_* result)
// Modes: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
module align_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  align_shifter_pipe_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH) + 1;

  // One shift step by a fixed amount s. Returns {any_bit_lost, result}.
  // The s == WIDTH step is identity for rotate so the amount wraps modulo WIDTH.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d,
                                                input logic [1:0] mode,
                                                input logic en,
                                                input int s);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] lost;
    ones = '1;
    r    = d;
    lost = '0;
    if (en) begin
      case (mode)
        2'b00: begin
          r    = d >> s;
          lost = d & ~(ones << s);
        end
        2'b01: begin
          // MSB still holds the original sign after earlier arithmetic steps
          r    = (d >> s) | (d[WIDTH-1] ? ~(ones >> s) : '0);
          lost = d & ~(ones << s);
        end
        2'b10: begin
          r    = d << s;
          lost = d & ~(ones >> s);
        end
        default: begin
          if (s < WIDTH) r = (d >> s) | (d << (WIDTH - s));
        end
      endcase
    end
    return {|lost, r};
  endfunction

  // Stage registers; mode/shamt are not needed after the last stage.
  logic             vld_p  [SHW];
  logic [WIDTH-1:0] data_p [SHW];
  logic             stk_p  [SHW];
  logic [TAGW-1:0]  tag_p  [SHW];
  logic [1:0]       mode_p [SHW-1];
  logic [SHW-1:0]   sh_p   [SHW-1];

  // Stage inputs (previous register, or the input port for stage 0)
  logic             src_vld  [SHW];
  logic [WIDTH-1:0] src_data [SHW];
  logic             src_stk  [SHW];
  logic [TAGW-1:0]  src_tag  [SHW];
  logic [1:0]       src_mode [SHW];
  logic [SHW-1:0]   src_sh   [SHW];
  logic [WIDTH:0]   step_res [SHW];

  logic advance;

  assign advance      = !vld_p[SHW-1] || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_vld[k]  = bus.in_valid;
      assign src_data[k] = bus.in_data;
      assign src_stk[k]  = 1'b0;
      assign src_tag[k]  = bus.in_tag;
      assign src_mode[k] = bus.in_mode;
      assign src_sh[k]   = bus.in_shamt;
    end else begin : g_next
      assign src_vld[k]  = vld_p[k-1];
      assign src_data[k] = data_p[k-1];
      assign src_stk[k]  = stk_p[k-1];
      assign src_tag[k]  = tag_p[k-1];
      assign src_mode[k] = mode_p[k-1];
      assign src_sh[k]   = sh_p[k-1];
    end
    assign step_res[k] = shift_step(src_data[k], src_mode[k], src_sh[k][SHW-1-k],
                                    1 << (SHW - 1 - k));
  end

  // Stage boundary: valids advance together, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHW; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) vld_p[k] <= src_vld[k];
    end
  end

  // Stage boundary: payload advances with the valids; only the output stage is cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p[SHW-1] <= '0;
      stk_p[SHW-1]  <= 1'b0;
      tag_p[SHW-1]  <= '0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        data_p[k] <= step_res[k][WIDTH-1:0];
        stk_p[k]  <= src_stk[k] | step_res[k][WIDTH];
        tag_p[k]  <= src_tag[k];
      end
      for (int k = 0; k < SHW - 1; k++) begin
        mode_p[k] <= src_mode[k];
        sh_p[k]   <= src_sh[k];
      end
    end
  end

  assign bus.out_valid  = vld_p[SHW-1];
  assign bus.out_data   = data_p[SHW-1];
  assign bus.out_sticky = stk_p[SHW-1];
  assign bus.out_tag    = tag_p[SHW-1];
endmodule

// File: tb/tb_align_shifter_pipe.sv
// Self-checking bench for align_shifter_pipe (WIDTH=8, TAGW=4).
module tb_align_shifter_pipe;
  localparam int W = 8;
  localparam int T = 4;

  logic clk;
  logic rst;

  align_shifter_pipe_if #(.WIDTH(W), .TAGW(T)) bus ();

  align_shifter_pipe #(.WIDTH(W), .TAGW(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int n_out;

  typedef struct {
    logic [T-1:0] tag;
    logic [W-1:0] data;
    logic         sticky;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   sh;
    logic [1:0]   m;
    logic [T-1:0] tag;
    logic [W-1:0] exp_d;
    logic         exp_s;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each mode computed directly from the total shift amount.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] d, input int sh,
                                           input logic [1:0] m);
    logic [2*W-1:0] dd;
    logic [W-1:0]   res;
    logic           stk;
    res = '0;
    stk = 1'b0;
    case (m)
      2'b00: begin
        if (sh >= W) begin res = '0; stk = |d; end
        else begin res = d >> sh; stk = |(d & W'((1 << sh) - 1)); end
      end
      2'b01: begin
        if (sh >= W) begin res = {W{d[W-1]}}; stk = |d; end
        else begin res = W'($signed(d) >>> sh); stk = |(d & W'((1 << sh) - 1)); end
      end
      2'b10: begin
        if (sh >= W) begin res = '0; stk = |d; end
        else begin res = d << sh; stk = |(d >> (W - sh)); end
      end
      default: begin
        dd  = {d, d};
        res = W'(dd >> (sh % W));
        stk = 1'b0;
      end
    endcase
    return {stk, res};
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle
  logic         prev_stall;
  logic [W-1:0] prev_d;
  logic         prev_s;
  logic [T-1:0] prev_t;
  initial prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(prev_d));
        check("hold_sticky", 32'(bus.out_sticky), 32'(prev_s));
        check("hold_tag", 32'(bus.out_tag), 32'(prev_t));
      end
      if (bus.out_valid && !bus.out_ready)
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        logic [W:0] r;
        r = ref_shift(bus.in_data, int'(bus.in_shamt), bus.in_mode);
        e.tag = bus.in_tag;
        e.data = r[W-1:0];
        e.sticky = r[W];
        q.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_tag", 32'(bus.out_tag), 32'(e.tag));
          check("sb_data", 32'(bus.out_data), 32'(e.data));
          check("sb_sticky", 32'(bus.out_sticky), 32'(e.sticky));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_d = bus.out_data;
      prev_s = bus.out_sticky;
      prev_t = bus.out_tag;
    end
  end

  // Offer one op and hold it until the handshake edge (bounded)
  task automatic send(input logic [W-1:0] d, input logic [3:0] sh,
                      input logic [1:0] m, input logic [T-1:0] tag);
    logic acc;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_mode  = m;
    bus.in_tag   = tag;
    guard = 0;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Single op into an empty pipe; checks latency and result
  task automatic run_one(input vec_t v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = v.d;
    bus.in_shamt = v.sh;
    bus.in_mode  = v.m;
    bus.in_tag   = v.tag;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) begin n = i; break; end
    end
    check("latency", 32'(n), 32'd4);
    check("vec_data", 32'(bus.out_data), 32'(v.exp_d));
    check("vec_sticky", 32'(bus.out_sticky), 32'(v.exp_s));
    check("vec_tag", 32'(bus.out_tag), 32'(v.tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int base;
    logic done;

    n_cmp = 0;
    n_fail = 0;
    n_out = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_shamt = '0;
    bus.in_mode = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;

    vecs[0] = '{8'hB4, 4'd3,  2'b00, 4'h1, 8'h16, 1'b1};
    vecs[1] = '{8'hB4, 4'd2,  2'b01, 4'h2, 8'hED, 1'b0};
    vecs[2] = '{8'h80, 4'd15, 2'b01, 4'h3, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 4'd9,  2'b00, 4'h4, 8'h00, 1'b1};
    vecs[4] = '{8'hB4, 4'd3,  2'b10, 4'h5, 8'hA0, 1'b1};
    vecs[5] = '{8'hB4, 4'd11, 2'b11, 4'h6, 8'h96, 1'b0};
    vecs[6] = '{8'h5A, 4'd0,  2'b00, 4'h7, 8'h5A, 1'b0};
    vecs[7] = '{8'h3C, 4'd8,  2'b11, 4'h8, 8'h3C, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    check("post_rst_data", 32'(bus.out_data), 32'd0);
    check("post_rst_sticky", 32'(bus.out_sticky), 32'd0);
    check("post_rst_tag", 32'(bus.out_tag), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) run_one(vecs[i]);

    // Back-to-back stream with a stall window
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(8'hB4 + 8'(i * 17), 4'(i * 3), 2'(i), 4'(i));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain(60);
    check("stream_count", 32'(n_out - base), 32'd6);

    // Reset with three ops in flight, plus an op offered during reset
    base = n_out;
    send(8'hF0, 4'd1, 2'b00, 4'hA);
    send(8'h0F, 4'd2, 2'b10, 4'hB);
    send(8'h81, 4'd3, 2'b01, 4'hC);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    bus.in_tag = 4'hD;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("flush_quiet", 32'(bus.out_valid), 32'd0);
    end
    check("flush_count", 32'(n_out - base), 32'd0);
    run_one('{8'hB4, 4'd3, 2'b00, 4'hE, 8'h16, 1'b1});

    // Random ops with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 4'($urandom));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
